edge_walk_sequencer: RTL
========================

# edge_walk_sequencer

Sequences the per-node successor walk for the path-counting engine. Accepts one node (index plus its accumulated path count) from the node scheduler, reads that node's successor list slot by slot from the adjacency memory, and emits one (successor index, path count) token per edge to the accumulator FIFO. It sits between the control FSM and the adjacency memory/FIFO write port, and owns all adjacency-memory read sequencing.

## Interface
- PARAM_NODE_IDX_WIDTH, 9, node index width
- PARAM_COUNTER_WIDTH, 4, edge-count and edge-slot width (max 2^W-1 successors)
- PARAM_ACCUM_VAL_WIDTH, 24, path-count width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  node request valid
- req_ready  out  1  sequencer can accept a request
- req_node_idx  in  NODE_IDX  node to expand
- req_accum_val  in  ACCUM_VAL  path count of that node
- mem_rd_en  out  1  adjacency read strobe
- mem_node_idx  out  NODE_IDX  node being read
- mem_edge_sel  out  COUNTER  successor slot being read
- mem_next_node_idx  in  NODE_IDX  successor at selected slot, valid 1 cycle after mem_rd_en
- mem_next_node_counter  in  COUNTER  node's successor count, valid with the data above
- out_valid  out  1  edge token valid
- out_ready  in  1  FIFO accepts token
- out_node_idx  out  NODE_IDX  successor index
- out_accum_val  out  ACCUM_VAL  path count carried to the successor
- out_last  out  1  token is the node's final edge
- busy  out  1  not in IDLE
- done  out  1  one-cycle pulse: node expansion finished

## Operation
- States: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE: req_ready=1. On req_valid: latch req_node_idx, req_accum_val; slot<=0; go ISSUE.
- ISSUE: mem_rd_en=1, mem_node_idx=latched idx, mem_edge_sel=slot; go WAIT.
- WAIT: capture mem_next_node_idx into out register. On slot 0 only, capture mem_next_node_counter as edge count; later reads ignore the counter input. If edge count==0: go DONE, no token. Else go EMIT.
- EMIT: out_valid=1; out_node_idx = captured successor, out_accum_val = latched accum (unchanged), out_last = (slot == count-1). On out_ready: if out_last go DONE, else slot<=slot+1, go ISSUE. Without out_ready, all out_* held stable.
- DONE: done=1 for one cycle; go IDLE.
- Count 2^W-1 (15 default): slots 0..14 emitted; slot never wraps.
- Outputs not named in a state are 0; mem_node_idx/mem_edge_sel hold last value.
- Reset values: state IDLE, req_ready=1 after reset release (0 while rst_n low is not required), all other outputs 0, slot 0, latched registers 0.
- Reset asserted mid-walk: immediate return to IDLE, token discarded, no done pulse.

## Timing
- Request accepted at cycle 0 -> ISSUE cycle 1 -> WAIT cycle 2 -> first out_valid cycle 3.
- With out_ready held high: one token every 3 cycles; node with N edges: done at cycle 3N+1 after acceptance.
- Zero-edge node: done at cycle 3.
- req_ready low from the cycle after acceptance until the cycle after done (back-to-back requests: next accept earliest cycle 3N+2).
- Handshake: transfer when valid & ready same cycle; out_valid never deasserts without transfer.

## Structure
- Shared package: state encoding localparams (3-bit), width defaults.
- Single module; no sub-module warranted. Slot counter and latched request live in the same always block as the state register.

## Test plan
- Node 5, accum 7, memory count 3, successors {12,40,300}, out_ready=1 -> tokens (12,7,last0),(40,7,last0),(300,7,last1) at cycles 3,6,9; done at cycle 10.
- Node 0 count 0 -> no out_valid, done at cycle 3, req_ready back at cycle 4.
- Count 3, out_ready low 5 cycles on token 2 -> out_node_idx/out_accum_val/out_last stable, transfer on ready, sequence completes with no loss or duplication.
- Count 15, accum 24'hFFFFFF -> 15 tokens, slots 0..14 on mem_edge_sel, out_last only on 15th, no wrap.
- Memory changes mem_next_node_counter on slot>0 reads -> emitted token count still matches slot-0 count.
- rst_n pulled low during EMIT of token 2 of 3 -> IDLE immediately, out_valid=0, no done; new request after release walks correctly from slot 0.

Source files
------------

// File: rtl/edge_walk_sequencer_pkg.sv
// Shared definitions for the edge-walk sequencer: default widths and the
// 3-bit walk-state encoding.
package edge_walk_sequencer_pkg;

  localparam int NODE_IDX_WIDTH  = 9;
  localparam int COUNTER_WIDTH   = 4;
  localparam int ACCUM_VAL_WIDTH = 24;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    EMIT  = ST_EMIT,
    DONE  = ST_DONE
  } walk_state_t;

endpackage

// File: rtl/edge_walk_sequencer.sv
// Expands one node into per-successor (index, path count) tokens by walking
// its adjacency list one slot at a time: issue read, capture, emit.
module edge_walk_sequencer
  import edge_walk_sequencer_pkg::*;
#(
  parameter int PARAM_NODE_IDX_WIDTH  = NODE_IDX_WIDTH,
  parameter int PARAM_COUNTER_WIDTH   = COUNTER_WIDTH,
  parameter int PARAM_ACCUM_VAL_WIDTH = ACCUM_VAL_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  req_node_idx,
  input  logic [PARAM_ACCUM_VAL_WIDTH-1:0] req_accum_val,
  output logic                             mem_rd_en,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  mem_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]   mem_edge_sel,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  mem_next_node_idx,
  input  logic [PARAM_COUNTER_WIDTH-1:0]   mem_next_node_counter,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  out_node_idx,
  output logic [PARAM_ACCUM_VAL_WIDTH-1:0] out_accum_val,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done
);

  walk_state_t                      state_q, state_d;
  logic [PARAM_NODE_IDX_WIDTH-1:0]  node_q;
  logic [PARAM_ACCUM_VAL_WIDTH-1:0] accum_q;
  logic [PARAM_COUNTER_WIDTH-1:0]   slot_q;
  logic [PARAM_COUNTER_WIDTH-1:0]   count_q;
  logic [PARAM_NODE_IDX_WIDTH-1:0]  succ_q;

  logic [PARAM_COUNTER_WIDTH-1:0]   edge_count;
  logic                             is_last;

  // The successor count is only trusted from the slot-0 read; later reads
  // may carry anything on the counter lane.
  assign edge_count = (slot_q == '0) ? mem_next_node_counter : count_q;
  assign is_last    = (slot_q == (count_q - 1'b1));

  // NOTE: every register, including the datapath latches, is cleared by reset
  // so mem_node_idx/mem_edge_sel come out of reset as zero rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      node_q  <= '0;
      accum_q <= '0;
      slot_q  <= '0;
      count_q <= '0;
      succ_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            node_q  <= req_node_idx;
            accum_q <= req_accum_val;
            slot_q  <= '0;
          end
        end
        WAIT: begin
          succ_q <= mem_next_node_idx;
          if (slot_q == '0) count_q <= mem_next_node_counter;
        end
        EMIT: begin
          if (out_ready && !is_last) slot_q <= slot_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_rd_en     = 1'b0;
    out_valid     = 1'b0;
    out_node_idx  = '0;
    out_accum_val = '0;
    out_last      = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ISSUE;
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        state_d = (edge_count == '0) ? DONE : EMIT;
      end
      EMIT: begin
        out_valid     = 1'b1;
        out_node_idx  = succ_q;
        out_accum_val = accum_q;
        out_last      = is_last;
        if (out_ready) state_d = is_last ? DONE : ISSUE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address lines follow the latched registers, so they hold between reads.
  assign mem_node_idx = node_q;
  assign mem_edge_sel = slot_q;
  assign busy         = (state_q != IDLE);

endmodule
